surf_cin_framer: RTL

Parametrised multi-channel command framer for the TURFIO→SURF CIN links. It runs in the sysclk domain and serialises CMD_WIDTH-bit command words into 4-bit nibbles, least-significant nibble first, one nibble per clock per channel. An external per-channel 4:1 DDR OSERDES consumes the nibbles. It replaces the single-channel fixed-width framer with these additions:
- N channels
- per-channel training and addressing masks
- a valid/ready command handshake
- sync-realignment status

---
 rtl/surf_cin_pkg.sv | 26 ++
 rtl/surf_cin_lane.sv | 63 ++++++
 rtl/surf_cin_framer.sv | 91 +++++++++
 3 files changed

// File: rtl/surf_cin_pkg.sv
// Shared constants and elaboration helpers for the SURF CIN command framer.
package surf_cin_pkg;

    // Width of one serialised unit handed to the per-lane 4:1 DDR OSERDES.
    localparam int unsigned NIBBLE_W = 4;

    // Default training pattern and idle word (32-bit command format).
    localparam logic [31:0] DEFAULT_TRAIN_VALUE = 32'hA55A_6996;
    localparam logic [31:0] DEFAULT_IDLE_VALUE  = 32'h0000_0000;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Clocks needed to send one command word.
    function automatic int unsigned frame_len(input int unsigned cmd_width);
        return cmd_width / NIBBLE_W;
    endfunction

    // Phase counter width; never narrower than one bit so a one-nibble word still
    // has a legal (constant zero) counter.
    function automatic int unsigned phase_width(input int unsigned cmd_width);
        int unsigned frame;
        frame = frame_len(cmd_width);
        return (frame > 1) ? $clog2(frame) : 1;
    endfunction

endpackage

// File: rtl/surf_cin_lane.sv
// One SURF CIN lane: holds the word being sent and emits one nibble per clock.
module surf_cin_lane
    import surf_cin_pkg::*;
#(
    parameter int unsigned          CMD_WIDTH   = 32,
    parameter int unsigned          PHASE_W     = 3,
    parameter logic [CMD_WIDTH-1:0] TRAIN_VALUE = CMD_WIDTH'(DEFAULT_TRAIN_VALUE),
    parameter logic [CMD_WIDTH-1:0] IDLE_VALUE  = CMD_WIDTH'(DEFAULT_IDLE_VALUE),
    parameter logic                 INVERT      = 1'b0
) (
    input  logic                 sysclk_i,
    input  logic                 rst_n_i,
    // Effective phase: which nibble of the held word goes out next.
    input  logic [PHASE_W-1:0]   ep_i,
    // Word boundary: replace the held word at the end of this cycle.
    input  logic                 load_i,
    // Lane training select, sampled only at a load.
    input  logic                 train_i,
    // Command handshake completed and this lane is addressed.
    input  logic                 accept_i,
    input  logic [CMD_WIDTH-1:0] command_i,
    output nibble_t              nibble_o
);

    // Lane polarity is applied after the mux so the held word stays in true polarity.
    localparam nibble_t INV_MASK = {NIBBLE_W{INVERT}};

    logic [CMD_WIDTH-1:0] hold_q, hold_d;
    nibble_t              nibble_q, nibble_d;

    // Next held word: training wins over commands, and an unaccepted slot sends idle.
    always_comb begin
        hold_d = hold_q;
        if (load_i) begin
            if (train_i) begin
                hold_d = TRAIN_VALUE;
            end else if (accept_i) begin
                hold_d = command_i;
            end else begin
                hold_d = IDLE_VALUE;
            end
        end
    end

    // Select the nibble for the effective phase (LS nibble first) and apply polarity.
    always_comb begin
        nibble_d = hold_q[ep_i * NIBBLE_W +: NIBBLE_W] ^ INV_MASK;
    end

    // Hold and output registers; reset puts idle on the wire with lane polarity applied.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_q   <= IDLE_VALUE;
            nibble_q <= IDLE_VALUE[NIBBLE_W-1:0] ^ INV_MASK;
        end else begin
            hold_q   <= hold_d;
            nibble_q <= nibble_d;
        end
    end

    assign nibble_o = nibble_q;

endmodule

// File: rtl/surf_cin_framer.sv
// Multi-lane TURFIO->SURF CIN command framer: serialises command words into nibbles,
// one nibble per clock per lane, aligned to an externally supplied frame sync.
module surf_cin_framer
    import surf_cin_pkg::*;
#(
    parameter int unsigned          NCHAN       = 7,
    parameter int unsigned          CMD_WIDTH   = 32,
    parameter logic [CMD_WIDTH-1:0] TRAIN_VALUE = CMD_WIDTH'(DEFAULT_TRAIN_VALUE),
    parameter logic [CMD_WIDTH-1:0] IDLE_VALUE  = CMD_WIDTH'(DEFAULT_IDLE_VALUE),
    parameter logic [NCHAN-1:0]     CIN_INV     = {NCHAN{1'b0}}
) (
    input  logic                      sysclk_i,
    input  logic                      rst_n_i,
    // High marks frame phase 0 for this cycle.
    input  logic                      sync_i,
    input  logic [NCHAN-1:0]          train_i,
    input  logic [CMD_WIDTH-1:0]      command_i,
    input  logic [NCHAN-1:0]          command_mask_i,
    input  logic                      command_valid_i,
    output logic                      command_ready_o,
    // Lane n occupies bits [4n+3:4n]; bit 0 leaves the OSERDES first.
    output logic [NIBBLE_W*NCHAN-1:0] nibble_o,
    output logic                      frame_start_o,
    output logic                      sync_realign_o
);

    localparam int unsigned        FRAME      = frame_len(CMD_WIDTH);
    localparam int unsigned        PHASE_W    = phase_width(CMD_WIDTH);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(FRAME - 1);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] ep;
    logic               load;
    logic               accept;
    logic               frame_start_q, frame_start_d;
    logic               sync_realign_q, sync_realign_d;

    // Sync forces phase 0 for this cycle; the counter then runs on from there, so a
    // mid-frame sync replays the current word from nibble 0 without reloading it.
    always_comb begin
        ep            = sync_i ? '0 : phase_q;
        load          = (ep == LAST_PHASE);
        phase_d       = load ? '0 : ep + PHASE_W'(1);
        frame_start_d = (ep == '0);
        // A sync landing on phase 0 agrees with the running count: no realignment.
        sync_realign_d = sync_i && (phase_q != '0);
    end

    // A command is taken only in the final phase of a frame, and never during a sync
    // cycle since that cycle is no longer the word boundary.
    always_comb begin
        command_ready_o = (phase_q == LAST_PHASE) && !sync_i;
        accept          = command_valid_i && command_ready_o;
    end

    // Phase counter and frame status registers.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q        <= '0;
            frame_start_q  <= 1'b0;
            sync_realign_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            frame_start_q  <= frame_start_d;
            sync_realign_q <= sync_realign_d;
        end
    end

    assign frame_start_o  = frame_start_q;
    assign sync_realign_o = sync_realign_q;

    for (genvar n = 0; n < NCHAN; n++) begin : g_lane
        surf_cin_lane #(
            .CMD_WIDTH   (CMD_WIDTH),
            .PHASE_W     (PHASE_W),
            .TRAIN_VALUE (TRAIN_VALUE),
            .IDLE_VALUE  (IDLE_VALUE),
            .INVERT      (CIN_INV[n])
        ) u_lane (
            .sysclk_i  (sysclk_i),
            .rst_n_i   (rst_n_i),
            .ep_i      (ep),
            .load_i    (load),
            .train_i   (train_i[n]),
            .accept_i  (accept && command_mask_i[n]),
            .command_i (command_i),
            .nibble_o  (nibble_o[NIBBLE_W*n +: NIBBLE_W])
        );
    end

endmodule
